// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer and FIFO write-side bundle shared by the round-robin write arbiter
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int IW = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          full;
   logic                          wr_enb;
   logic [DATA_WIDTH-1:0]         wr_data;
   logic [IW-1:0]                 grant_id;
   logic                          busy;
   modport master (
      output req_valid, req_data, full,
      input  req_ready, wr_enb, wr_data, grant_id, busy
   );
   modport slave (
      input  req_valid, req_data, full,
      output req_ready, wr_enb, wr_data, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input logic          wr_clk,
   input logic          rst,
   fifo_wr_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t          state;
   logic [IW-1:0]   gid, rr_ptr, sel, nxt;
   logic [CW-1:0]   beat_cnt;
   logic            live, accept, last;
   // walk from farthest to nearest so the first valid at or after rr_ptr wins
   always_comb begin
      int idx;
      idx = 0;
      sel = rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
         if (bus.req_valid[idx]) sel = IW'(idx);
      end
   end
   assign live          = (state == GRANT) && !rst;
   assign accept        = live && !bus.full && bus.req_valid[gid];
   assign last          = beat_cnt == CW'(MAX_BURST - 1);
   assign nxt           = (gid == IW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
   assign bus.req_ready = (live && !bus.full) ? NUM_REQ'(1) << gid : '0;
   assign bus.wr_enb    = accept;
   assign bus.wr_data   = bus.req_data[gid*DATA_WIDTH +: DATA_WIDTH];
   assign bus.grant_id  = rst ? '0 : gid;
   assign bus.busy      = live;
   always_ff @(posedge wr_clk) begin
      if (rst) begin
         state    <= IDLE;
         gid      <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else if (state == IDLE) begin
         if (!bus.full && |bus.req_valid) begin
            state    <= GRANT;
            gid      <= sel;
            beat_cnt <= '0;
         end
      end else if (!bus.req_valid[gid] || (accept && last)) begin
         state    <= IDLE;
         rr_ptr   <= nxt;
         beat_cnt <= '0;
      end else if (accept) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random checks of the write arbiter against a grant/burst reference model
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;
   logic wr_clk = 1'b0;
   logic rst    = 1'b1;
   always #5 wr_clk = ~wr_clk;
   fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .wr_clk (wr_clk),
      .rst    (rst),
      .bus    (bus)
   );
   int         checks = 0, errors = 0;
   int         owner = -1, beats = 0, ptr = 0, m_gid = 0;
   int         seq [N];
   logic [7:0] base [N];
   int         dut_wr = 0, fcnt = 0;
   bit         use_fifo = 0;
   logic       prev_busy = 1'b0;
   int         grants [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_g(input int i, input int e);
      chk("grant_order", (i < grants.size()) ? grants[i] : -1, e);
   endtask

   // one clock: drive at negedge, check combinational outputs, then advance the model at posedge
   task automatic step(input logic [N-1:0] v, input logic fl, input logic rs);
      logic           eb, ew;
      logic [N-1:0]   er;
      bit             rel;
      @(negedge wr_clk);
      rst           = rs;
      bus.req_valid = v;
      bus.full      = use_fifo ? (fcnt == 8) : fl;
      for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = 8'(base[i] + seq[i]);
      #1;
      eb = (owner >= 0) && !rs;
      er = (eb && !bus.full) ? N'(1) << owner : '0;
      ew = eb && !bus.full && v[owner];
      chk("busy", bus.busy, eb);
      chk("req_ready", bus.req_ready, er);
      chk("wr_enb", bus.wr_enb, ew);
      chk("grant_id", bus.grant_id, rs ? 0 : m_gid);
      if (ew) chk("wr_data", bus.wr_data, 8'(base[owner] + seq[owner]));
      if (use_fifo) chk("no_overflow", bus.wr_enb && bus.full, 0);
      if (bus.wr_enb === 1'b1) dut_wr++;
      if (bus.busy === 1'b1 && prev_busy !== 1'b1) grants.push_back(int'(bus.grant_id));
      prev_busy = bus.busy;
      @(posedge wr_clk);
      rel = 0;
      if (ew) seq[owner]++;
      if (use_fifo) fcnt = fcnt + int'(ew) - ((fcnt > 0 && $urandom_range(0, 3) == 0) ? 1 : 0);
      if (rs) begin
         owner = -1; beats = 0; ptr = 0; m_gid = 0;
      end else if (owner < 0) begin
         if (!bus.full && |v)
            for (int k = 0; k < N; k++)
               if (owner < 0 && v[(ptr + k) % N]) begin
                  owner = (ptr + k) % N; m_gid = owner; beats = 0;
               end
      end else if (!v[owner]) begin
         rel = 1;
      end else if (ew) begin
         beats++;
         rel = (beats == MB);
      end
      if (rel) begin
         ptr = (owner + 1) % N; owner = -1; beats = 0;
      end
   endtask

   initial begin
      base = '{8'h10, 8'hA0, 8'h50, 8'hC0};
      for (int i = 0; i < N; i++) seq[i] = 0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.full      = 1'b0;
      // reset then single requester streaming A0..A5
      repeat (2) step('0, 0, 1);
      dut_wr = 0; grants.delete();
      repeat (8) step(4'b0010, 0, 0);
      repeat (2) step('0, 0, 0);
      chk("single_writes", dut_wr, 6);
      chk("single_grants", grants.size(), 2);
      chk_g(0, 1); chk_g(1, 1);
      // round robin, all valid
      step('0, 0, 1);
      dut_wr = 0; grants.delete();
      repeat (25) step(4'b1111, 0, 0);
      chk("rr_writes", dut_wr, 20);
      chk("rr_grants", grants.size(), 5);
      chk_g(0, 0); chk_g(1, 1); chk_g(2, 2); chk_g(3, 3); chk_g(4, 0);
      // full stall mid-burst on requester 2
      step('0, 0, 1);
      dut_wr = 0; grants.delete();
      repeat (3) step(4'b0100, 0, 0);
      repeat (3) step(4'b0100, 1, 0);
      repeat (2) step(4'b0100, 0, 0);
      chk("stall_writes", dut_wr, 4);
      repeat (2) step(4'b1111, 0, 0);
      chk_g(0, 2); chk_g(1, 3);
      // early release of requester 0
      step('0, 0, 1);
      grants.delete();
      repeat (2) step(4'b0001, 0, 0);
      repeat (3) step(4'b0010, 0, 0);
      chk_g(0, 0); chk_g(1, 1);
      // full while idle, then reset mid-burst
      step('0, 0, 1);
      grants.delete();
      repeat (3) step(4'b1111, 1, 0);
      chk("idle_full_nogrant", grants.size(), 0);
      repeat (3) step(4'b1000, 0, 0);
      step(4'b1000, 0, 1);
      repeat (2) step(4'b0110, 0, 0);
      repeat (2) step('0, 0, 0);
      chk_g(0, 3); chk_g(1, 1);
      // random traffic into a modelled 8-deep FIFO
      step('0, 0, 1);
      use_fifo = 1; fcnt = 0;
      repeat (200) step(N'($urandom_range(0, 15)), 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the FIFO. It shares the single FIFO write port (wr_enb / input_data) between NUM_REQ independent producers in the wr_clk domain. Each producer gets a grant for a bounded burst, and the arbiter applies backpressure from the FIFO `full` flag. It sits between producer logic and the FIFO write side, and the rd_clk side is untouched.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 8: write data width; must equal the FIFO data width.
- MAX_BURST, 4: maximum beats per grant (1..16).

Ports:
- wr_clk  in  1  write-domain clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- full  in  1  FIFO full flag (write domain).
- wr_enb  out  1  FIFO write enable.
- wr_data  out  DATA_WIDTH  FIFO write data, drives input_data.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high while in GRANT.

## Operation
- Registered state: state (IDLE, GRANT), grant_id, rr_ptr ($clog2(NUM_REQ) bits), beat_cnt ($clog2(MAX_BURST+1) bits).
- IDLE:
  - If full=0 and any req_valid is set, select the first valid index searching upward from rr_ptr with modulo wrap. Register it into grant_id, clear beat_cnt, and go to GRANT.
  - If full=1 or no valid, stay in IDLE and hold grant_id.
- GRANT, with g = grant_id:
  - req_ready[g] = !full. All other ready bits are 0.
  - A beat is accepted when req_valid[g] && req_ready[g].
  - wr_enb = beat accepted (combinational). wr_data = req_data slice g (combinational).
  - Beat accepted with beat_cnt == MAX_BURST-1: release the grant.
  - Beat accepted otherwise: beat_cnt increments by 1.
  - req_valid[g] = 0: release the grant. No write occurs.
  - full=1 with req_valid[g]=1: stall. Grant is held, beat_cnt is held, wr_enb=0.
  - On release: go to IDLE and set rr_ptr = (g+1) mod NUM_REQ. beat_cnt clears.
- Valid bits of non-granted requesters are ignored during GRANT.
- wr_enb never asserts while full=1. This is the overflow guarantee.
- rr_ptr wraps from NUM_REQ-1 to 0. For non-power-of-2 NUM_REQ, use an explicit compare, not a bit truncation.

## Timing
- Reset: during any cycle with rst=1, the arbiter drives the following, and nothing is written that cycle:
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0
  - wr_enb=0, req_ready=0, busy=0
- Reset mid-burst: the burst is abandoned with no further beats. The first cycle after rst drops is IDLE.
- Arbitration latency: requester valid in IDLE at cycle N gives GRANT with ready high at cycle N+1. The first write is at cycle N+1 if full=0.
- Burst: MAX_BURST beats in consecutive cycles if valid stays high and full=0.
- Release costs one IDLE cycle, so the maximum sustained throughput is MAX_BURST writes per MAX_BURST+1 cycles.
- Fairness bound: a continuously valid requester is granted within (NUM_REQ-1)*(MAX_BURST+1)+1 cycles, excluding cycles with full=1.
- full is sampled combinationally in the same cycle as the beat. The FIFO's full must reflect all writes up to the previous edge, which the FIFO write-pointer logic provides.
- busy = (state == GRANT). grant_id changes only on the IDLE→GRANT edge.

## Test plan
- **Reset then single requester:** rst high 2 cycles; req_valid=4'b0010 with data 8'hA0..A5 streamed → grant_id=1; 4 writes A0..A3 on cycles 1-4 after grant request; IDLE 1 cycle; regrant to 1; A4,A5 written. wr_enb=0 and ready=0 during reset.
- **Round-robin order:** all four valid continuously, full=0 → grant_id sequence 0,1,2,3,0. Each grant gives exactly 4 wr_enb pulses, then 1 idle cycle. 20 writes in 25 cycles.
- **Full stall:** requester 2 mid-burst after 2 beats, full forced 1 for 3 cycles → wr_enb=0 and ready[2]=0 for 3 cycles, grant held. After full drops, the remaining 2 beats complete, then release to rr_ptr=3.
- **Early release:** requester 0 drops valid after 1 beat → next cycle IDLE and rr_ptr=1. Requester 1 (valid) is granted the following cycle.
- **Full in IDLE plus reset mid-burst:** full=1 with requesters valid → stays IDLE, no grant. Then full=0, grant 3; assert rst after beat 2 → next cycle wr_enb=0, state IDLE, rr_ptr=0. Next grant goes to lowest valid index from 0.
- **Scoreboard against the real FIFO:** connect to the FIFO, random valids, 200 cycles → no write while full=1. Per-requester data order is preserved at the FIFO output.
